// File: rtl/imem_loader_pkg.sv
// Shared definitions for the boot-time instruction-memory loader: FSM encodings
// and the default imem depth used by both the loader and the processor's imem.
package imem_loader_pkg;

    localparam int IMEM_WORDS = 4096;

    typedef enum logic [2:0] {
        LDR_HDR  = 3'd0,
        LDR_DATA = 3'd1,
        LDR_SUM  = 3'd2,
        LDR_DONE = 3'd3,
        LDR_ERR  = 3'd4
    } ldr_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

endpackage

// File: rtl/imem_loader_uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampler with start-bit glitch
// rejection, one-cycle byte_valid and a combinational frame_err on a low stop bit.
//
// state    | meaning
// RX_IDLE  | waiting for a falling edge on the synchronized line
// RX_START | counting to mid start bit; high there means glitch
// RX_DATA  | sampling 8 data bits LSB first at mid-bit
// RX_STOP  | sampling the stop bit at mid-bit
module uart_rx
    import imem_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       frame_err
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

    rx_state_t     state, state_nxt;
    logic [2:0]    sync;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic          line, fall, tick;

    // sync[1] is the synchronized line, sync[2] its previous value for edge detect
    assign line = sync[1];
    assign fall = sync[2] & ~sync[1];
    assign tick = (cnt == '0);

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync <= 3'b111;
        end else begin
            sync <= {sync[1:0], rxd};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= RX_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RX_IDLE:  if (fall) state_nxt = RX_START;
            RX_START: if (tick) state_nxt = line ? RX_IDLE : RX_DATA;
            RX_DATA:  if (tick && bit_idx == 3'd7) state_nxt = RX_STOP;
            RX_STOP:  if (tick) state_nxt = RX_IDLE;
            default:  state_nxt = RX_IDLE;
        endcase
    end

    always_comb begin
        frame_err = 1'b0;
        if (state == RX_STOP && tick && !line) frame_err = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt        <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            rx_byte    <= '0;
            byte_valid <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            case (state)
                RX_IDLE: begin
                    cnt     <= HALF;
                    bit_idx <= '0;
                end
                RX_START: begin
                    cnt <= tick ? FULL : cnt - CW'(1);
                end
                RX_DATA: begin
                    if (tick) begin
                        shift   <= {line, shift[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        cnt     <= FULL;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                RX_STOP: begin
                    if (tick) begin
                        byte_valid <= line;
                        rx_byte    <= shift;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: cnt <= HALF;
            endcase
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: receives a length-prefixed little-endian program image over UART and
// writes it into imem, holding the CPU in reset until done. IMEM_LOADER_CHECKSUM_EN adds a trailing sum check.
//
// state    | meaning
// LDR_HDR  | collecting the 4-byte word count
// LDR_DATA | collecting words and writing them to imem
// LDR_SUM  | collecting and comparing the trailing checksum
// LDR_DONE | image loaded, CPU released
// LDR_ERR  | load failed, CPU held in reset
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int WORD         = IMEM_WORDS,
    parameter int AW           = $clog2(WORD)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rxd,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_data,
    output logic          mem_we,
    output logic          cpu_rst,
    output logic          busy,
    output logic          done,
    output logic          err
);

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam ldr_state_t AFTER_DATA = LDR_SUM;
`else
    localparam ldr_state_t AFTER_DATA = LDR_DONE;
`endif

    ldr_state_t    state, state_nxt;
    logic [7:0]    rx_byte;
    logic          byte_valid, frame_err;
    logic [1:0]    k;
    logic [31:0]   len, word;
    logic [31:0]   len_full, word_full;
    logic [AW:0]   remaining;
    logic [AW-1:0] next_addr;
    logic          last_byte, collecting;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0]   sum;
`endif

    uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk        (clk),
        .rst        (rst),
        .rxd        (rxd),
        .rx_byte    (rx_byte),
        .byte_valid (byte_valid),
        .frame_err  (frame_err)
    );

    // Full 32-bit values as they will look once the current (4th) byte is shifted in
    assign len_full   = {rx_byte, len[31:8]};
    assign word_full  = {rx_byte, word[23:0]};
    assign last_byte  = byte_valid && (k == 2'd3);
    assign collecting = (state == LDR_HDR) || (state == LDR_DATA) || (state == LDR_SUM);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= LDR_HDR;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            LDR_HDR: begin
                if (frame_err) begin
                    state_nxt = LDR_ERR;
                end else if (last_byte) begin
                    if (len_full == '0)               state_nxt = AFTER_DATA;
                    else if (len_full > 32'(WORD))    state_nxt = LDR_ERR;
                    else                              state_nxt = LDR_DATA;
                end
            end
            LDR_DATA: begin
                if (frame_err)                          state_nxt = LDR_ERR;
                else if (mem_we && remaining == '0)     state_nxt = AFTER_DATA;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            LDR_SUM: begin
                if (frame_err)      state_nxt = LDR_ERR;
                else if (last_byte) state_nxt = (word_full == sum) ? LDR_DONE : LDR_ERR;
            end
`endif
            default: state_nxt = state;
        endcase
    end

    always_comb begin
        cpu_rst = 1'b1;
        busy    = 1'b0;
        done    = 1'b0;
        err     = 1'b0;
        case (state)
            LDR_HDR:  busy = (k != 2'd0);
            LDR_DATA: busy = 1'b1;
            LDR_SUM:  busy = 1'b1;
            LDR_DONE: begin
                cpu_rst = 1'b0;
                done    = 1'b1;
            end
            LDR_ERR:  err = 1'b1;
            default:  busy = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            k         <= '0;
            len       <= '0;
            word      <= '0;
            remaining <= '0;
            next_addr <= '0;
            mem_addr  <= '0;
            mem_data  <= '0;
            mem_we    <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum       <= '0;
`endif
        end else begin
            mem_we <= 1'b0;
            if (byte_valid && collecting) begin
                k <= k + 2'd1;
                if (state == LDR_HDR) len <= len_full;
                else                  word[{k, 3'b000} +: 8] <= rx_byte;
            end
            if (state == LDR_HDR && last_byte) begin
                remaining <= len_full[AW:0];
            end
            if (state == LDR_DATA && last_byte) begin
                mem_we    <= 1'b1;
                mem_data  <= word_full;
                mem_addr  <= next_addr;
                next_addr <= next_addr + AW'(1);
                remaining <= remaining - (AW+1)'(1);
`ifdef IMEM_LOADER_CHECKSUM_EN
                sum       <= sum + word_full;
`endif
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table-driven frames, hand-written corner
// sequences and randomized frames checked against an array-based model of the image.
module tb_imem_loader;

    localparam int CPB = 16;
    localparam int AW  = 12;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          rxd = 1'b1;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_data;
    logic          mem_we, cpu_rst, busy, done, err;

    imem_loader #(.CLKS_PER_BIT(CPB), .WORD(4096), .AW(AW)) dut (
        .clk      (clk),
        .rst      (rst),
        .rxd      (rxd),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .mem_we   (mem_we),
        .cpu_rst  (cpu_rst),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int byte_no  = 0;

    // write monitor
    int            cyc          = 0;
    int            last_we_cyc  = -1;
    int            rst_fall_cyc = -1;
    int            double_we    = 0;
    logic          we_prev      = 1'b0;
    logic          cpu_rst_prev = 1'b1;
    logic [AW-1:0] wq_addr[$];
    logic [31:0]   wq_data[$];

    always @(negedge clk) begin
        cyc          <= cyc + 1;
        we_prev      <= mem_we;
        cpu_rst_prev <= cpu_rst;
        if (mem_we) begin
            wq_addr.push_back(mem_addr);
            wq_data.push_back(mem_data);
            last_we_cyc <= cyc;
            if (we_prev) double_we <= double_we + 1;
        end
        if (!cpu_rst && cpu_rst_prev) rst_fall_cyc <= cyc;
    end

    logic [31:0] frame_words[16];

    typedef struct {
        logic [31:0] len;
        int          nsend;
        int          bad_byte;
        logic [31:0] w0, w1, w2;
        int          exp_writes;
        logic        exp_done;
        logic        exp_err;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rxd = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (CPB) @(negedge clk);
        end
        rxd = stop;
        repeat (CPB) @(negedge clk);
        rxd = 1'b1;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w, input int bad_byte);
        for (int i = 0; i < 4; i++) begin
            byte_no++;
            send_byte(w[8*i +: 8], byte_no != bad_byte);
        end
    endtask

    // Sends header + nsend words; checksum build appends sum^sum_xor, default build
    // appends it as trailing junk only when sum_xor is non-zero.
    task automatic send_frame(input logic [31:0] len, input int nsend, input int bad_byte,
                              input logic [31:0] sum_xor);
        logic [31:0] s;
        s       = '0;
        byte_no = 0;
        send_word(len, bad_byte);
        for (int j = 0; j < nsend; j++) begin
            send_word(frame_words[j], bad_byte);
            s = s + frame_words[j];
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_word(s ^ sum_xor, bad_byte);
`else
        if (sum_xor != '0) send_word(s ^ sum_xor, bad_byte);
`endif
    endtask

    task automatic do_reset();
        rxd = 1'b1;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_end(input string name);
        int n;
        n = 0;
        while (!(done || err) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({name, "_timeout"}, 32'(n < 200), 32'd1);
        repeat (3) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_addr"},    32'(mem_addr), 32'd0);
        check({name, "_data"},    mem_data,      32'd0);
        check({name, "_we"},      32'(mem_we),   32'd0);
        check({name, "_cpu_rst"}, 32'(cpu_rst),  32'd1);
        check({name, "_busy"},    32'(busy),     32'd0);
        check({name, "_done"},    32'(done),     32'd0);
        check({name, "_err"},     32'(err),      32'd0);
    endtask

    task automatic check_result(input string name, input int base, input int exp_writes,
                                input logic exp_done, input logic exp_err);
        int got;
        got = wq_data.size() - base;
        check({name, "_nwrites"}, 32'(got), 32'(exp_writes));
        for (int i = 0; i < exp_writes && i < got; i++) begin
            check($sformatf("%s_addr%0d", name, i), 32'(wq_addr[base+i]), 32'(i));
            check($sformatf("%s_data%0d", name, i), wq_data[base+i], frame_words[i]);
        end
        check({name, "_done"},    32'(done),    32'(exp_done));
        check({name, "_err"},     32'(err),     32'(exp_err));
        check({name, "_cpu_rst"}, 32'(cpu_rst), 32'(!exp_done));
        check({name, "_busy"},    32'(busy),    32'd0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int n, bad, exp_w;
        logic [31:0] sx;
        logic exp_e;

        vecs[0] = '{32'd2,    2, -1, 32'h8C010000, 32'h00000000, 32'h0,        2, 1'b1, 1'b0};
        vecs[1] = '{32'd0,    0, -1, 32'h0,        32'h0,        32'h0,        0, 1'b1, 1'b0};
        vecs[2] = '{32'd4097, 0, -1, 32'h0,        32'h0,        32'h0,        0, 1'b0, 1'b1};
        vecs[3] = '{32'd2,    2,  6, 32'h8C010000, 32'h00000000, 32'h0,        0, 1'b0, 1'b1};
        vecs[4] = '{32'd3,    3, -1, 32'h01234567, 32'h89ABCDEF, 32'hDEADBEEF, 3, 1'b1, 1'b0};
        vecs[5] = '{32'd1,    1,  8, 32'hFFFFFFFF, 32'h0,        32'h0,        0, 1'b0, 1'b1};

        do_reset();
        check_reset_outputs("reset");

        for (int v = 0; v < 6; v++) begin
            do_reset();
            frame_words[0] = vecs[v].w0;
            frame_words[1] = vecs[v].w1;
            frame_words[2] = vecs[v].w2;
            base = wq_data.size();
            send_frame(vecs[v].len, vecs[v].nsend, vecs[v].bad_byte, 32'h0);
            wait_end($sformatf("vec%0d", v));
            check_result($sformatf("vec%0d", v), base, vecs[v].exp_writes,
                         vecs[v].exp_done, vecs[v].exp_err);
`ifndef IMEM_LOADER_CHECKSUM_EN
            if (vecs[v].exp_done && vecs[v].exp_writes > 0)
                check($sformatf("vec%0d_release_lat", v), 32'(rst_fall_cyc), 32'(last_we_cyc + 1));
`endif
        end

        // glitch on idle line must not produce a byte
        do_reset();
        rxd = 1'b0;
        repeat (CPB / 4) @(negedge clk);
        rxd = 1'b1;
        repeat (12 * CPB) @(negedge clk);
        check("glitch_busy", 32'(busy), 32'd0);
        frame_words[0] = 32'hA5A55A5A;
        base = wq_data.size();
        send_frame(32'd1, 1, -1, 32'h0);
        wait_end("glitch");
        check_result("glitch", base, 1, 1'b1, 1'b0);

        // reset mid-word, then a fresh frame
        do_reset();
        base    = wq_data.size();
        byte_no = 0;
        send_word(32'd1, -1);
        send_byte(8'h44, 1'b1);
        send_byte(8'h33, 1'b1);
        check("midrst_busy", 32'(busy), 32'd1);
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("midrst");
        check("midrst_nwrites", 32'(wq_data.size() - base), 32'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        frame_words[0] = 32'hCAFEF00D;
        base = wq_data.size();
        send_frame(32'd1, 1, -1, 32'h0);
        wait_end("midrst_reload");
        check_result("midrst_reload", base, 1, 1'b1, 1'b0);

`ifdef IMEM_LOADER_CHECKSUM_EN
        frame_words[0] = 32'hFFFFFFFF;
        frame_words[1] = 32'h00000002;
        do_reset();
        base = wq_data.size();
        send_frame(32'd2, 2, -1, 32'h0);
        wait_end("sum_good");
        check_result("sum_good", base, 2, 1'b1, 1'b0);
        do_reset();
        base = wq_data.size();
        send_frame(32'd2, 2, -1, 32'h3);
        wait_end("sum_bad");
        check_result("sum_bad", base, 2, 1'b0, 1'b1);
`endif

        // randomized frames; model: word i lands at address i, complete words before a
        // bad stop bit are still written, a wrong checksum fails after all writes
        for (int r = 0; r < 6; r++) begin
            do_reset();
            n = int'($urandom_range(1, 4));
            for (int j = 0; j < n; j++) frame_words[j] = $urandom;
            sx  = ($urandom_range(0, 1) == 1) ? ($urandom | 32'h1) : 32'h0;
            bad = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4 + 4 * n)) : -1;
            exp_w = n;
`ifdef IMEM_LOADER_CHECKSUM_EN
            exp_e = (sx != 32'h0);
`else
            exp_e = 1'b0;
`endif
            if (bad > 0) begin
                exp_e = 1'b1;
                exp_w = (bad <= 4) ? 0 : (bad - 5) / 4;
            end
            base = wq_data.size();
            send_frame(32'(n), n, bad, sx);
            wait_end($sformatf("rand%0d", r));
            check_result($sformatf("rand%0d", r), base, exp_w, !exp_e, exp_e);
        end

        check("we_single_cycle", 32'(double_we), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader: the write side of the processor's instruction memory. It receives a program image over a UART line (8N1), assembles little-endian 32-bit words, and writes them sequentially into the imem write port. It holds the processor in reset until the image is complete. It sits between the board RX pin and the imem `in`/`we`/`addr` port, and drives the processor's active-high reset.

## Interface
- `CLKS_PER_BIT`, 434: clk cycles per UART bit (50 MHz / 115200); must be ≥ 8.
- `WORD`, 4096: imem depth in words; maximum accepted image length.
- `AW`, 12: imem word-address width, clog2(`WORD`).
- `clk` input 1: system clock.
- `rst` input 1: reset, synchronous, active-low; clock `clk`.
- `rxd` input 1: asynchronous UART line, idle high.
- `mem_addr` output `AW`: imem word address for the current write.
- `mem_data` output 32: imem write data.
- `mem_we` output 1: one-cycle write strobe.
- `cpu_rst` output 1: active-high processor reset; high until a successful load.
- `busy` output 1: a frame is in progress (a header byte has been received and the loader is not yet in DONE or ERR).
- `done` output 1: image loaded, processor released.
- `err` output 1: load failed; sticky until `rst`.

## Operation
- `rxd` passes through a 2-flop synchronizer before any use.
- UART receive:
  - A falling edge starts a bit counter. The start bit is re-sampled at `CLKS_PER_BIT/2`; if it reads high, the glitch is ignored and the receiver returns to idle.
  - Eight data bits are sampled LSB first at the middle of each bit.
  - The stop bit is sampled at mid-bit. Stop = 1 raises a one-cycle `byte_valid`. Stop = 0 is a framing error.
- Frame format: 4-byte length N (little-endian word count), then N words of 4 bytes each, little-endian. With `IMEM_LOADER_CHECKSUM_EN`, a 4-byte trailing checksum follows.
- FSM states: HDR → DATA → (SUM) → DONE; any state may go to ERR.
  - HDR: shift bytes into the length register. After byte 4:
    - N == 0 → DONE (→ SUM when checksum is enabled).
    - N > `WORD` → ERR.
    - Otherwise → DATA.
  - DATA: shift each byte into `word[8*k +: 8]`, where k is a 2-bit byte index. After byte 3, issue the write, increment the address, and decrement the remaining count. Remaining == 0 after the write → DONE (or SUM).
  - SUM: collect 4 bytes and compare against the running sum. Equal → DONE; unequal → ERR.
  - DONE: terminal. `cpu_rst` = 0, `done` = 1. Further RX bytes are ignored.
  - ERR: terminal. `cpu_rst` = 1, `err` = 1. Entered on a framing error in any non-terminal state.
- Address arithmetic: `mem_addr` starts at 0 and increments by 1 per write. It cannot wrap, because N ≤ `WORD` is enforced.
- Checksum arithmetic: 32-bit sum of all data words, modulo 2^32; the length word is not included.

## Timing
- Reset values: `mem_addr` = 0, `mem_data` = 0, `mem_we` = 0, `cpu_rst` = 1, `busy` = 0, `done` = 0, `err` = 0. The FSM resets to HDR, the receiver to idle, and the byte index to 0.
- `byte_valid` fires 1 cycle after the stop-bit mid-sample.
- Writes:
  - `mem_we` asserts for exactly 1 cycle, the cycle after the 4th byte's `byte_valid`.
  - `mem_addr` and `mem_data` are stable during that cycle and hold afterwards.
  - At most one write occurs per 4 byte times, so there is no backpressure.
- Completion: `done` and `cpu_rst` = 0 assert in the cycle after the final write (or after the final checksum byte). The processor's first instruction fetch therefore sees fully written memory.
- `rst` asserted mid-frame: all state returns to reset values at the next edge, and a partial word is never written. The sender must restart from the header.
- Stop-bit failure: ERR is entered the cycle after the stop-bit sample, and no write is issued for a partial word.

## Configuration
- `IMEM_LOADER_CHECKSUM_EN` defined: SUM state present, with the running-sum register and comparator. Frame = 4 + 4N + 4 bytes.
- Not defined: no SUM state; DATA → DONE directly. Frame = 4 + 4N bytes. Any trailing bytes after the last word are ignored.

## Structure
- Shared package/include (alongside `INST.v`): FSM state encodings (`LDR_HDR`, `LDR_DATA`, `LDR_SUM`, `LDR_DONE`, `LDR_ERR`) and the default imem depth constant shared with the processor's imem instance.
- One sub-module: `uart_rx`. Parameter `CLKS_PER_BIT`; ports `clk`, `rst`, `rxd`; outputs `byte` [7:0], `byte_valid`, `frame_err`. It contains the synchronizer, the bit counter, and the sampler.

## Test plan
- N = 2, words 0x8C010000 and 0x00000000 (checksum disabled) → two `mem_we` pulses at addr 0 and 1 with exactly those data values; `cpu_rst` falls 1 cycle after the 2nd pulse; `done` = 1.
- N = 0 → no `mem_we` pulse; `done` = 1 after the 4th header byte.
- N = 4097 → `err` = 1; `cpu_rst` stays 1; no writes occur.
- Stop bit driven low on byte 6 → `err` = 1; zero writes; later bytes are ignored.
- 0.25-bit low glitch on idle `rxd`, then a valid frame → the glitch produces no byte; the frame loads normally.
- `IMEM_LOADER_CHECKSUM_EN`, words 0xFFFFFFFF and 0x00000002: checksum 0x00000001 → `done`; checksum 0x00000002 → `err`. `rst` pulled low mid-word → outputs return to reset values, and a fresh frame then loads correctly.
